// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, controller states
// and instruction field positions.
package processador_pkg;

  localparam logic [3:0] OP_0   = 4'd0;
  localparam logic [3:0] OP_1   = 4'd1;
  localparam logic [3:0] OP_2   = 4'd2;
  localparam logic [3:0] OP_3   = 4'd3;
  localparam logic [3:0] OP_4   = 4'd4;
  localparam logic [3:0] OP_5   = 4'd5;
  localparam logic [3:0] OP_IMM = 4'd6;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RC_MSB  = 11;
  localparam int unsigned RC_LSB  = 8;
  localparam int unsigned RA_MSB  = 7;
  localparam int unsigned RA_LSB  = 4;
  localparam int unsigned RB_MSB  = 3;
  localparam int unsigned RB_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_READ,
    ST_EXEC,
    ST_WRITE
  } ctrl_state_t;

endpackage

// File: rtl/unidade_controle_if.sv
// Handshake, register-bank and ALU signals between the sequencer and datapath.
interface unidade_controle_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
);
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic [DATA_W-1:0] alu_result;
  logic [ADDR_W-1:0] reg_a;
  logic [ADDR_W-1:0] reg_b;
  logic [ADDR_W-1:0] reg_c;
  logic              reg_rw;
  logic [DATA_W-1:0] reg_dado;
  logic [4:0]        alu_codop;
  logic [DATA_W-1:0] alu_imm;
  logic              alu_sel_imm;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  instr_valid, instr, alu_result,
    output instr_ready, reg_a, reg_b, reg_c, reg_rw, reg_dado,
           alu_codop, alu_imm, alu_sel_imm, busy, done, err
  );

  modport slave (
    output instr_valid, instr, alu_result,
    input  instr_ready, reg_a, reg_b, reg_c, reg_rw, reg_dado,
           alu_codop, alu_imm, alu_sel_imm, busy, done, err
  );
endinterface

// File: rtl/unidade_controle_decodificador.sv
// Combinational instruction decoder. UNIDADE_CONTROLE_IMM_EN enables opcode 6
// as the immediate instruction; otherwise opcode 6 is illegal.
module decodificador_instr
  import processador_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [15:0]       i_instr,
  output logic [ADDR_W-1:0] o_reg_a,
  output logic [ADDR_W-1:0] o_reg_b,
  output logic [ADDR_W-1:0] o_reg_c,
  output logic [4:0]        o_codop,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_is_imm,
  output logic              o_illegal
);
  logic [3:0] w_opc;
  logic [3:0] w_ra;

  assign w_opc = i_instr[OPC_MSB:OPC_LSB];
  assign w_ra  = i_instr[RA_MSB:RA_LSB];

  always_comb begin
    o_reg_c = ADDR_W'(i_instr[RC_MSB:RC_LSB]);
    o_reg_b = ADDR_W'(i_instr[RB_MSB:RB_LSB]);
    o_codop = 5'(w_opc);
`ifdef UNIDADE_CONTROLE_IMM_EN
    o_is_imm  = (w_opc == OP_IMM);
    o_illegal = (w_opc > OP_5) && !o_is_imm;
    // Immediate form reuses the ra field as imm4, so bank port A is parked at 0
    o_reg_a   = o_is_imm ? '0 : ADDR_W'(w_ra);
    o_imm     = o_is_imm ? DATA_W'(w_ra) : '0;
`else
    o_is_imm  = 1'b0;
    o_illegal = (w_opc > OP_5);
    o_reg_a   = ADDR_W'(w_ra);
    o_imm     = '0;
`endif
  end
endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle sequencer: IDLE -> DECODE -> READ -> EXEC -> WRITE, one instruction
// at a time. UNIDADE_CONTROLE_IMM_EN (see decoder) enables the immediate opcode.
module unidade_controle
  import processador_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
) (
  input logic              clk,
  input logic              rst,
  unidade_controle_if.master bus
);
  ctrl_state_t       r_state;
  ctrl_state_t       w_next;
  logic [15:0]       r_ir;
  logic              r_err;
  logic [DATA_W-1:0] r_dado;

  logic [ADDR_W-1:0] w_reg_a;
  logic [ADDR_W-1:0] w_reg_b;
  logic [ADDR_W-1:0] w_reg_c;
  logic [4:0]        w_codop;
  logic [DATA_W-1:0] w_imm;
  logic              w_is_imm;
  logic              w_illegal;

  // Decoded fields come straight from ir, so they hold until the next accept
  decodificador_instr #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_dec (
    .i_instr  (r_ir),
    .o_reg_a  (w_reg_a),
    .o_reg_b  (w_reg_b),
    .o_reg_c  (w_reg_c),
    .o_codop  (w_codop),
    .o_imm    (w_imm),
    .o_is_imm (w_is_imm),
    .o_illegal(w_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
      r_err   <= 1'b0;
      r_dado  <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == ST_DECODE) && w_illegal;
      if ((r_state == ST_IDLE) && bus.instr_valid) r_ir <= bus.instr;
      if (r_state == ST_WRITE) r_dado <= bus.alu_result;
    end
  end

  always_comb begin
    w_next          = r_state;
    bus.instr_ready = 1'b0;
    bus.busy        = 1'b1;
    bus.reg_rw      = 1'b0;
    bus.done        = 1'b0;
    bus.reg_dado    = r_dado;
    case (r_state)
      ST_IDLE: begin
        bus.instr_ready = 1'b1;
        bus.busy        = 1'b0;
        if (bus.instr_valid) w_next = ST_DECODE;
      end
      ST_DECODE: w_next = w_illegal ? ST_IDLE : ST_READ;
      ST_READ:   w_next = ST_EXEC;
      ST_EXEC:   w_next = ST_WRITE;
      ST_WRITE: begin
        bus.reg_rw   = 1'b1;
        bus.done     = 1'b1;
        bus.reg_dado = bus.alu_result;
        w_next       = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  assign bus.err         = r_err;
  assign bus.reg_a       = w_reg_a;
  assign bus.reg_b       = w_reg_b;
  assign bus.reg_c       = w_reg_c;
  assign bus.alu_codop   = w_codop;
  assign bus.alu_imm     = w_imm;
  assign bus.alu_sel_imm = w_is_imm;
endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: randomized instruction words checked
// against a cycle-offset reference model of the sequencer's observable behaviour.
module tb_unidade_controle;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic [15:0] last_dado = '0;

`ifdef UNIDADE_CONTROLE_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  int          q_acc[$];
  int          q_rw[$];
  int          q_done[$];
  int          q_err[$];
  logic [15:0] q_dado[$];

  unidade_controle_if #(.DATA_W(16), .ADDR_W(5)) bus ();

  unidade_controle #(.DATA_W(16), .ADDR_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.reg_rw === 1'b1) begin
      q_rw.push_back(cyc);
      q_dado.push_back(bus.reg_dado);
    end
    if (bus.done === 1'b1) q_done.push_back(cyc);
    if (bus.err === 1'b1) q_err.push_back(cyc);
    if (bus.instr_valid && bus.instr_ready === 1'b1 && !rst) q_acc.push_back(cyc);
  end

  // 0 = register-register, 1 = immediate, 2 = illegal
  function automatic int kind_of(logic [15:0] w);
    int op;
    op = int'(w) / 4096;
    if (op <= 5) return 0;
    if (op == 6 && IMM_EN) return 1;
    return 2;
  endfunction

  // Expected {reg_c, reg_a, reg_b, alu_codop, alu_imm, alu_sel_imm} after decoding w
  function automatic logic [36:0] exp_fld(logic [15:0] w);
    int op, c, a, b;
    bit imm;
    op  = int'(w) / 4096;
    c   = (int'(w) / 256) % 16;
    a   = (int'(w) / 16) % 16;
    b   = int'(w) % 16;
    imm = (kind_of(w) == 1);
    return {5'(c), imm ? 5'd0 : 5'(a), 5'(b), 5'(op), imm ? 16'(a) : 16'd0, imm};
  endfunction

  // Expected {instr_ready, busy, reg_rw, done, err} k cycles after the accept cycle
  function automatic logic [4:0] exp_ctl(int kind, int k);
    if (kind == 2) return {k >= 2, k == 1, 1'b0, 1'b0, k == 2};
    return {k >= 5, k <= 4, k == 4, k == 4, 1'b0};
  endfunction

  function automatic logic [4:0] act_ctl();
    return {bus.instr_ready, bus.busy, bus.reg_rw, bus.done, bus.err};
  endfunction

  function automatic logic [36:0] act_fld();
    return {bus.reg_c, bus.reg_a, bus.reg_b, bus.alu_codop, bus.alu_imm, bus.alu_sel_imm};
  endfunction

  // Presents w until accepted; t is the accept cycle. Returns at the start of T+1.
  task automatic issue(input logic [15:0] w, input logic [15:0] va, output int t, output bit ok);
    ok = 1'b0;
    t  = -1;
    @(posedge clk); #1;
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.instr_ready === 1'b1 && !rst) begin
        t  = cyc;
        ok = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.alu_result  = va;
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.alu_result  = 16'h5A5A;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (act_ctl() !== 5'b10000) $display("FAIL reset_ctl: got %b expected %b", act_ctl(), 5'b10000);
    else n_pass++;
    n_total++;
    if (act_fld() !== 37'd0) $display("FAIL reset_fields: got %h expected %h", act_fld(), 37'd0);
    else n_pass++;
    n_total++;
    if (bus.reg_dado !== 16'h0) $display("FAIL reset_dado: got %h expected 0000", bus.reg_dado);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 bus.alu_result = 16'($urandom);
      @(negedge clk);
      n_total++;
      if (act_ctl() !== 5'b10000 || bus.reg_dado !== 16'h0)
        $display("FAIL idle_quiet cycle %0d: ctl %b dado %h expected ctl 10000 dado 0000",
                 i, act_ctl(), bus.reg_dado);
      else n_pass++;
    end
    last_dado = '0;
  endtask

  task automatic test_single_instr();
    logic [15:0] words[$];
    logic [15:0] w, va, exp_d;
    int t, kind, kmax;
    bit ok;
    words = '{16'h2123, 16'h64F5, 16'hA123};
    for (int i = 0; i < 24; i++) begin
      int op;
      case (i % 3)
        0:       op = int'($urandom_range(0, 5));
        1:       op = 6;
        default: op = int'($urandom_range(7, 15));
      endcase
      words.push_back({4'(op), 12'($urandom)});
    end
    foreach (words[j]) begin
      w    = words[j];
      kind = kind_of(w);
      va   = (j == 0) ? 16'h00AA : 16'($urandom);
      issue(w, va, t, ok);
      n_total++;
      if (!ok) begin
        $display("FAIL accept %h: not accepted within 20 cycles", w);
        continue;
      end
      n_pass++;
      kmax = (kind == 2) ? 3 : 6;
      for (int k = 1; k <= kmax; k++) begin
        @(negedge clk);
        n_total++;
        if (act_ctl() !== exp_ctl(kind, k))
          $display("FAIL ctl instr %h T+%0d: got %b expected %b", w, k, act_ctl(), exp_ctl(kind, k));
        else n_pass++;
        exp_d = (kind != 2 && k >= 4) ? va : last_dado;
        n_total++;
        if (bus.reg_dado !== exp_d)
          $display("FAIL reg_dado instr %h T+%0d: got %h expected %h", w, k, bus.reg_dado, exp_d);
        else n_pass++;
        if (k == 1 || k == kmax) begin
          n_total++;
          if (act_fld() !== exp_fld(w))
            $display("FAIL fields instr %h T+%0d: got %h expected %h", w, k, act_fld(), exp_fld(w));
          else n_pass++;
        end
      end
      if (kind != 2) last_dado = va;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va, vb;
    int t1, gap_acc, gap_done;
    va = 16'($urandom);
    vb = 16'($urandom);
    q_acc.delete(); q_done.delete(); q_rw.delete(); q_dado.delete();
    @(posedge clk); #1;
    bus.instr       = 16'h0123;
    bus.instr_valid = 1'b1;
    t1 = -1;
    for (int i = 0; i < 20 && t1 < 0; i++) begin
      @(negedge clk);
      if (bus.instr_ready === 1'b1) t1 = cyc;
      else begin
        @(posedge clk); #1;
      end
    end
    n_total++;
    if (t1 < 0) begin
      $display("FAIL b2b_first_accept: not accepted within 20 cycles");
      bus.instr_valid = 1'b0;
      return;
    end
    n_pass++;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      case (c)
        1: begin
          bus.instr       = 16'h1456;
          bus.alu_result  = va;
          bus.instr_valid = 1'($urandom);
        end
        2, 3: bus.instr_valid = 1'($urandom);
        4, 5: bus.instr_valid = 1'b1;
        6: begin
          bus.instr_valid = 1'b0;
          bus.alu_result  = vb;
        end
        default: ;
      endcase
    end
    @(negedge clk);
    gap_acc  = (q_acc.size() == 2) ? q_acc[1] - q_acc[0] : -1;
    gap_done = (q_done.size() == 2) ? q_done[1] - q_done[0] : -1;
    n_total++;
    if (gap_acc !== 5) $display("FAIL b2b_accept_gap: got %0d expected 5 (accepts %0d)", gap_acc, q_acc.size());
    else n_pass++;
    n_total++;
    if (gap_done !== 5) $display("FAIL b2b_done_gap: got %0d expected 5 (dones %0d)", gap_done, q_done.size());
    else n_pass++;
    n_total++;
    if (q_done.size() == 0 || q_done[0] !== t1 + 4)
      $display("FAIL b2b_first_done: got %0d expected %0d", q_done.size() ? q_done[0] : -1, t1 + 4);
    else n_pass++;
    n_total++;
    if (q_dado.size() != 2 || q_dado[0] !== va || q_dado[1] !== vb)
      $display("FAIL b2b_write_data: got %0d writes, expected %h then %h", q_dado.size(), va, vb);
    else n_pass++;
    last_dado = vb;
  endtask

  task automatic test_reset_exec();
    logic [15:0] w;
    int t;
    bit ok;
    w = {4'($urandom_range(0, 5)), 12'($urandom)};
    q_rw.delete(); q_done.delete(); q_err.delete(); q_dado.delete();
    issue(w, 16'($urandom), t, ok);
    n_total++;
    if (!ok) begin
      $display("FAIL rst_exec_accept: not accepted within 20 cycles");
      return;
    end
    n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL rst_exec_busy: got %b expected 1", bus.busy);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (act_ctl() !== 5'b10000) $display("FAIL rst_exec_ctl: got %b expected %b", act_ctl(), 5'b10000);
    else n_pass++;
    n_total++;
    if (act_fld() !== 37'd0 || bus.reg_dado !== 16'h0)
      $display("FAIL rst_exec_outputs: fields %h dado %h expected all zero", act_fld(), bus.reg_dado);
    else n_pass++;
    repeat (6) @(negedge clk);
    n_total++;
    if (q_rw.size() != 0 || q_done.size() != 0 || q_err.size() != 0)
      $display("FAIL rst_exec_no_write: got rw %0d done %0d err %0d expected none",
               q_rw.size(), q_done.size(), q_err.size());
    else n_pass++;
    last_dado = '0;
  endtask

  initial begin
    test_reset();
    test_single_instr();
    test_back_to_back();
    test_reset_exec();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle instruction sequencer for the register-bank/ALU datapath. It accepts one 16-bit instruction word per handshake, decodes opcode and register fields, and drives the bank read addresses, the ALU opcode and immediate, and the bank write-back. Transfers are ordered as decode, read, execute, write. It replaces ad-hoc switch/key sequencing at the top level, so one instruction completes cleanly before the next is accepted.

## Interface
Parameters:
- `DATA_W`, 16, datapath width (bank data, ALU result, immediate).
- `ADDR_W`, 5, bank address width; the 4-bit instruction fields are zero-extended into it.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction word present.
- `instr`  in  16  fields: `[15:12]` opcode, `[11:8]` rc (destination), `[7:4]` ra (or imm4), `[3:0]` rb.
- `instr_ready`  out  1  controller can accept; high only in IDLE.
- `alu_result`  in  DATA_W  registered ALU output.
- `reg_a`, `reg_b`, `reg_c`  out  ADDR_W each  bank read A, read B and write addresses.
- `reg_rw`  out  1  bank write enable; one-cycle pulse.
- `reg_dado`  out  DATA_W  bank write data.
- `alu_codop`  out  5  ALU opcode, zero-extended from `instr[15:12]`.
- `alu_imm`  out  DATA_W  immediate operand.
- `alu_sel_imm`  out  1  1 selects `alu_imm` instead of bank port A as ALU operand 1.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse per committed instruction.
- `err`  out  1  one-cycle pulse per rejected instruction.

## Operation
- States: IDLE, DECODE, READ, EXEC, WRITE.
- **IDLE**
  - `instr_ready=1`.
  - When `instr_valid & instr_ready`, latch `instr` into `ir` and go to DECODE.
- **DECODE**
  - Drive `reg_c={0,ir[11:8]}`, `reg_a={0,ir[7:4]}`, `reg_b={0,ir[3:0]}`, `alu_codop={0,ir[15:12]}`.
  - Opcodes 0–5 (register-register): `alu_sel_imm=0`, `alu_imm=0`. Go to READ.
  - Opcode 6 (immediate): `alu_imm={12'b0,ir[7:4]}`, `alu_sel_imm=1`, `reg_a=0`. Go to READ.
  - Opcodes 7–15 are illegal: return to IDLE, pulse `err` on the next cycle, no write.
- **READ:** wait one cycle for the bank read outputs. Go to EXEC.
- **EXEC:** wait one cycle for the ALU to register its result. Go to WRITE.
- **WRITE**
  - `reg_rw=1`, `reg_dado=alu_result`, `done=1`. Go to IDLE.
- Hold behaviour:
  - `reg_a/b/c`, `alu_codop`, `alu_imm` and `alu_sel_imm` hold their DECODE values until the next DECODE.
  - `reg_dado` holds its last written value.
- `instr_valid` outside IDLE is ignored; the source must hold it until accepted.
- rc equal to ra or rb needs no special handling: the write happens only after execute.

## Timing
- Accept edge at cycle T. Then DECODE is T+1, READ T+2, EXEC T+3, WRITE T+4.
- `reg_rw` and `done` are high during T+4 only; bank write occurs on the T+4→T+5 edge.
- `instr_ready` rises at T+5, so the maximum throughput is one instruction per 5 cycles.
- Illegal opcode: DECODE at T+1; IDLE with `err=1` at T+2; `instr_ready=1` at T+2.
- Reset values: state IDLE; `ir=0`; all address, data, opcode and immediate outputs 0; `reg_rw`, `alu_sel_imm`, `busy`, `done`, `err` all 0; `instr_ready=1` one cycle after reset is released.
- Reset mid-instruction aborts it with no write. If `rst` is asserted during WRITE, `reg_rw` is 0 from the next edge; the write on that same edge still commits.
- `rst` has priority over the handshake in IDLE.

## Configuration
- `UNIDADE_CONTROLE_IMM_EN`
  - Defined: opcode 6 is the immediate instruction described above.
  - Undefined: opcode 6 is illegal like 7–15, `alu_sel_imm` is tied to 0, `alu_imm` is tied to 0, and the immediate logic is removed.

## Structure
- Shared package `processador_pkg`:
  - opcode constants `OP_0`..`OP_5`, `OP_IMM=4'd6`;
  - state enum `ctrl_state_t`;
  - field slice constants (OPC_MSB/LSB, RC, RA, RB).
- One sub-module, `decodificador_instr`, combinational. From the 16-bit word it produces:
  - zero-extended addresses, ALU opcode, immediate;
  - `is_imm` and `illegal` flags.
- The FSM and output registers stay in `unidade_controle`.

## Test plan
- Reset, then idle: after `rst` is released, `instr_ready=1`, `busy=0`, every output 0, and `reg_rw` never pulses with `instr_valid=0` for 20 cycles.
- Register-register: `instr=16'h2123`, ALU stub returns `16'h00AA` in EXEC. Expect:
  - `alu_codop=5'd2`, `reg_c=1`, `reg_a=2`, `reg_b=3`;
  - `reg_rw=1` with `reg_dado=16'h00AA` exactly 4 cycles after accept;
  - `done` is a single pulse.
- Immediate, macro defined: `instr=16'h64F5`. Expect `alu_imm=16'h000F`, `alu_sel_imm=1`, `reg_c=4`, `reg_b=5`, write at T+4. With the macro undefined, expect an `err` pulse at T+2 and no `reg_rw`.
- Illegal opcode: `instr=16'hA123`. Expect `err` for one cycle at T+2, `reg_rw` never asserts, and `instr_ready=1` at T+2.
- Back-to-back: `instr_valid` held high with `16'h0123` then `16'h1456`. Expect the second accept at T+5 and two `done` pulses 5 cycles apart; `instr_valid` toggling during `busy` changes nothing.
- Reset in EXEC: assert `rst` at T+3. Expect no `reg_rw`, all outputs 0 and `instr_ready=1` after `rst` is deasserted.
